// File: rtl/alu_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_pipe                                                      |
// | Purpose  : Pipelined N-bit ALU with valid/ready on both sides. One       |
// |            operation per cycle. Result, flags and a pass-through tag     |
// |            leave STAGES register stages later. Backpressure from the     |
// |            consumer collapses bubbles upstream before stalling the input.|
// | Ports    : clk, rst              - clock, synchronous active-high reset  |
// |            in_valid/in_ready     - request handshake                     |
// |            in_a, in_b, in_op     - operands and opcode                   |
// |            in_tag                - caller tag, returned with the result  |
// |            out_valid/out_ready   - response handshake                    |
// |            out_y                 - result                                |
// |            out_zero/carry/ovf    - status flags                          |
// |            out_tag               - tag of this response                  |
// |            txn_count             - completed output handshakes (wraps)   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module alu_pipe #(
    parameter int N      = 16,
    parameter int STAGES = 2,
    parameter int TAG_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_y,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      txn_count
);

    localparam int SHW = $clog2(N);
    // Stage payload layout: {tag, ovf, carry, zero, y}
    localparam int DW  = TAG_W + 3 + N;

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_AND = 3'd2;
    localparam logic [2:0] c_OP_OR  = 3'd3;
    localparam logic [2:0] c_OP_XOR = 3'd4;
    localparam logic [2:0] c_OP_SHL = 3'd5;
    localparam logic [2:0] c_OP_SHR = 3'd6;
    localparam logic [2:0] c_OP_SLT = 3'd7;

    // ------------------------------------------------------------------
    // ALU datapath (combinational, feeds stage 0)
    // ------------------------------------------------------------------
    logic [N:0]   w_sum;
    logic [N-1:0] w_diff;
    logic [N-1:0] w_y;
    logic         w_carry;
    logic         w_ovf;
    logic         w_zero;
    logic [DW-1:0] w_res;

    always_comb begin
        w_sum   = {1'b0, in_a} + {1'b0, in_b};
        w_diff  = in_a - in_b;
        w_y     = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (in_op)
            c_OP_ADD: begin
                w_y     = w_sum[N-1:0];
                w_carry = w_sum[N];
                w_ovf   = (in_a[N-1] == in_b[N-1]) && (w_sum[N-1] != in_a[N-1]);
            end
            c_OP_SUB: begin
                w_y     = w_diff;
                // Borrow: the unsigned subtraction wrapped below zero
                w_carry = (in_a < in_b);
                w_ovf   = (in_a[N-1] != in_b[N-1]) && (w_diff[N-1] != in_a[N-1]);
            end
            c_OP_AND: w_y = in_a & in_b;
            c_OP_OR:  w_y = in_a | in_b;
            c_OP_XOR: w_y = in_a ^ in_b;
            // Only the low log2(N) bits of b form the shift amount
            c_OP_SHL: w_y = in_a << in_b[SHW-1:0];
            c_OP_SHR: w_y = in_a >> in_b[SHW-1:0];
            c_OP_SLT: w_y = {{(N-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            default:  w_y = '0;
        endcase
        w_zero = (w_y == '0);
    end

    assign w_res = {in_tag, w_ovf, w_carry, w_zero, w_y};

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic [STAGES-1:0] r_v;
    logic [DW-1:0]     r_d [STAGES];
    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_src_v;
    logic [DW-1:0]     w_src_d [STAGES];
    logic              w_cons;

    // Walk from the output back to the input. A stage may load when it is
    // empty or when it is handing its contents downstream this cycle; the
    // latter reduces to "the stage below can load", so the running term
    // is simply OR-ed with the stage's own emptiness.
    always_comb begin
        logic room;
        w_load = '0;
        room   = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            room      = !r_v[k] || room;
            w_load[k] = room;
        end
    end

    assign w_src_v[0] = in_valid;
    assign w_src_d[0] = w_res;

    generate
        for (genvar k = 1; k < STAGES; k++) begin : g_stage
            assign w_src_v[k] = r_v[k-1];
            assign w_src_d[k] = r_d[k-1];
        end
    endgenerate

    // Data is loaded together with the valid bit even when the source is
    // a bubble; empty stage data is don't-care, and the last stage only
    // changes when it is allowed to, which keeps held outputs stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_d[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_v[k] <= w_src_v[k];
                    r_d[k] <= w_src_d[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Transaction counter
    // ------------------------------------------------------------------
    logic [31:0] r_txn;

    assign w_cons = r_v[STAGES-1] && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_txn <= '0;
        end else if (w_cons) begin
            r_txn <= r_txn + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = w_load[0];
    assign out_valid = r_v[STAGES-1];
    assign {out_tag, out_ovf, out_carry, out_zero, out_y} = r_d[STAGES-1];
    assign txn_count = r_txn;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_pipe                                                   |
// | Purpose  : Directed and random self-checking bench for alu_pipe          |
// |            (N=16, STAGES=2, TAG_W=8).                                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_alu_pipe;

    localparam int N      = 16;
    localparam int STAGES = 2;
    localparam int TAG_W  = 8;
    localparam int RW     = TAG_W + 3 + N;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic [2:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_y;
    logic             out_zero;
    logic             out_carry;
    logic             out_ovf;
    logic [TAG_W-1:0] out_tag;
    logic [31:0]      txn_count;

    alu_pipe #(
        .N      (N),
        .STAGES (STAGES),
        .TAG_W  (TAG_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_zero  (out_zero),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .out_tag   (out_tag),
        .txn_count (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [RW-1:0] outs;
    assign outs = {out_tag, out_ovf, out_carry, out_zero, out_y};

    int            n_cmp;
    int            n_err;
    int            n_tx;
    int            n_rx;
    logic          last_acc;
    logic          hold_pend;
    logic [RW-1:0] hold_val;
    logic [RW-1:0] sbq [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model, packed as {tag, ovf, carry, zero, y}
    function automatic logic [RW-1:0] model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [2:0] op, input logic [7:0] t);
        int sa, sb, ua, ub, s;
        logic [15:0] y;
        logic c, o;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        c  = 1'b0;
        o  = 1'b0;
        y  = 16'h0;
        case (op)
            3'd0: begin
                y = a + b;
                c = (ua + ub) > 65535;
                s = sa + sb;
                o = (s > 32767) || (s < -32768);
            end
            3'd1: begin
                y = a - b;
                c = ua < ub;
                s = sa - sb;
                o = (s > 32767) || (s < -32768);
            end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: y = a << b[3:0];
            3'd6: y = a >> b[3:0];
            default: y = (sa < sb) ? 16'd1 : 16'd0;
        endcase
        return {t, o, c, (y == 16'h0), y};
    endfunction

    // One clock cycle: settle, score both handshakes, step past the edge.
    task automatic run_cycle();
        #1;
        if (hold_pend) chk("hold", {out_valid, outs}, {1'b1, hold_val});
        hold_pend = out_valid && !out_ready;
        hold_val  = outs;
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) chk("spurious_out", out_valid, 1'b0);
            else chk("resp", outs, sbq.pop_front());
            n_rx++;
        end
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            sbq.push_back(model(in_a, in_b, in_op, in_tag));
            n_tx++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
        hold_pend = 1'b0;
        last_acc  = 1'b0;
        n_tx = 0;
        n_rx = 0;
    endtask

    task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [2:0] op, input logic [7:0] t,
                            input logic [15:0] ey, input logic ez, input logic ec,
                            input logic eo, input bit chk_lat);
        int n;
        out_ready = 1'b1;
        in_a = a; in_b = b; in_op = op; in_tag = t;
        in_valid = 1'b1;
        run_cycle();
        chk({tag, "_acc"}, last_acc, 1'b1);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            run_cycle();
            n++;
        end
        if (chk_lat) chk({tag, "_lat"}, n, STAGES - 1);
        chk(tag, outs, {t, eo, ec, ez, ey});
        run_cycle();
    endtask

    initial begin
        int nt;
        int cyc;
        n_cmp = 0; n_err = 0; n_tx = 0; n_rx = 0;
        hold_pend = 1'b0; hold_val = '0; last_acc = 1'b0;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Reset state
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_txn", txn_count, 32'd0);
        chk("rst_outs", outs, '0);

        // Directed vectors: name, a, b, op, tag, y, zero, carry, ovf
        directed("add_wrap", 16'hFFFF, 16'h0001, 3'd0, 8'h11, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("txn_after_first", txn_count, 32'd1);
        directed("add_ovf",  16'h7FFF, 16'h0001, 3'd0, 8'h12, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
        directed("sub_brw",  16'h0003, 16'h0005, 3'd1, 8'h13, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0);
        directed("sub_ovf",  16'h8000, 16'h0001, 3'd1, 8'h14, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0);
        directed("slt_t",    16'hFFFF, 16'h0001, 3'd7, 8'h15, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("slt_f",    16'h0001, 16'hFFFF, 3'd7, 8'h16, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        directed("shl",      16'h0001, 16'h0013, 3'd5, 8'h17, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("shr",      16'h8000, 16'h000F, 3'd6, 8'h18, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("and",      16'hF0F0, 16'hFF00, 3'd2, 8'h19, 16'hF000, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("or",       16'hF0F0, 16'hFF00, 3'd3, 8'h1A, 16'hFFF0, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("xor",      16'hF0F0, 16'hFF00, 3'd4, 8'h1B, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("txn_directed", txn_count, 32'd11);

        // Backpressure: five back-to-back requests against a stalled sink
        do_reset();
        out_ready = 1'b0;
        nt = 1;
        for (int i = 0; i < 6; i++) begin
            in_valid = (nt <= 5);
            in_a = 16'(nt); in_b = 16'h0100; in_op = 3'd0; in_tag = 8'(nt);
            run_cycle();
            if (last_acc) nt++;
        end
        chk("bp_accepts", nt - 1, 2);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        chk("bp_head_tag", out_tag, 8'd1);
        out_ready = 1'b1;
        cyc = 0;
        while ((n_rx < 5) && (cyc < 50)) begin
            in_valid = (nt <= 5);
            in_a = 16'(nt); in_b = 16'h0100; in_op = 3'd0; in_tag = 8'(nt);
            run_cycle();
            if (last_acc) nt++;
            cyc++;
        end
        in_valid = 1'b0;
        run_cycle();
        chk("bp_rx", n_rx, 5);
        chk("bp_txn", txn_count, 32'd5);
        chk("bp_drained", out_valid, 1'b0);

        // Random streaming with random backpressure
        do_reset();
        cyc = 0;
        while ((n_rx < 1000) && (cyc < 20000)) begin
            if (!(in_valid && !last_acc)) begin
                if ((n_tx < 1000) && ($urandom_range(0, 3) != 0)) begin
                    in_valid = 1'b1;
                    in_a   = 16'($urandom);
                    in_b   = 16'($urandom);
                    in_op  = 3'($urandom_range(0, 7));
                    in_tag = 8'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            run_cycle();
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_rx", n_rx, 1000);
        chk("stream_tx", n_tx, 1000);
        chk("stream_txn", txn_count, 32'd1000);

        // Mid-flight reset with in_valid held high during reset
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_a = 16'h1234; in_b = 16'h1111; in_op = 3'd1; in_tag = 8'(8'h40 + i);
            run_cycle();
        end
        chk("mid_inflight", out_valid, 1'b1);
        in_tag = 8'h77;
        do_reset();
        in_valid = 1'b0;
        chk("mid_out_valid", out_valid, 1'b0);
        chk("mid_txn", txn_count, 32'd0);
        chk("mid_in_ready", in_ready, 1'b1);
        chk("mid_outs", outs, '0);
        out_ready = 1'b1;
        run_cycle();
        run_cycle();
        chk("mid_rst_ignore", out_valid, 1'b0);
        directed("post_rst", 16'h1234, 16'h1111, 3'd1, 8'h5A, 16'h0123, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("post_txn", txn_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
